pe_noc_interface: RTL and testbench



---
 rtl/pe_noc_interface.sv | 241 ++++++++++++++++++++++++
 tb/tb_pe_noc_interface.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_noc_interface.sv
// Network interface between a PE and a mesh router's in_pe/out_pe ports (4-phase bundled data).
// Optional ejection address filter and drop counter are enabled with `define NI_ADDR_CHECK_EN.
module pe_noc_interface #(
    parameter int ADDR_X = 1,
    parameter int ADDR_Y = 1,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pe_tx_valid,
    output logic        pe_tx_ready,
    input  logic [3:0]  pe_tx_dest,
    input  logic [23:0] pe_tx_data,
    output logic        inj_req,
    output logic [32:0] inj_data,
    input  logic        inj_ack,
    input  logic        ej_req,
    input  logic [32:0] ej_data,
    output logic        ej_ack,
    output logic        pe_rx_valid,
    input  logic        pe_rx_ready,
    output logic [3:0]  pe_rx_src,
    output logic [23:0] pe_rx_data,
    output logic [7:0]  drop_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [3:0]    SELF_ADDR = {2'(ADDR_X), 2'(ADDR_Y)};
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    typedef enum logic [1:0] {
        INJ_IDLE = 2'd0,
        INJ_LOAD = 2'd1,
        INJ_REQ  = 2'd2,
        INJ_RET  = 2'd3
    } inj_state_t;

    typedef enum logic {
        EJ_WAIT = 1'b0,
        EJ_ACK  = 1'b1
    } ej_state_t;

    logic [32:0]   fifo_mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_s;
    logic          pop_s;

    logic [1:0]    ack_sync_r;
    logic [1:0]    req_sync_r;
    logic          ack_s;
    logic          req_s;

    inj_state_t    inj_state_r;
    inj_state_t    inj_next_s;
    logic          inj_req_r;
    logic [32:0]   inj_data_r;

    ej_state_t     ej_state_r;
    ej_state_t     ej_next_s;
    logic          ej_ack_r;
    logic          capture_s;
    logic          accept_s;
    logic          rx_valid_r;
    logic [3:0]    rx_src_r;
    logic [23:0]   rx_data_r;

    // No full-bypass: readiness depends on occupancy only, never on a same-cycle pop.
    assign pe_tx_ready = (count_r != FULL_CNT);
    assign push_s      = pe_tx_valid & pe_tx_ready;

    // FIFO storage; packets are assembled here so the injection side just copies an entry
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {1'b1, pe_tx_dest, SELF_ADDR, pe_tx_data};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Two-flop synchronizers for the router-side handshake inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync_r <= 2'b00;
            req_sync_r <= 2'b00;
        end else begin
            ack_sync_r <= {ack_sync_r[0], inj_ack};
            req_sync_r <= {req_sync_r[0], ej_req};
        end
    end

    assign ack_s = ack_sync_r[1];
    assign req_s = req_sync_r[1];

    // Injection FSM next-state and pop decision
    always_comb begin
        inj_next_s = inj_state_r;
        pop_s      = 1'b0;
        case (inj_state_r)
            INJ_IDLE: begin
                if (count_r != {CW{1'b0}}) begin
                    pop_s      = 1'b1;
                    inj_next_s = INJ_LOAD;
                end else begin
                    inj_next_s = INJ_IDLE;
                end
            end
            INJ_LOAD: inj_next_s = INJ_REQ;
            INJ_REQ: begin
                if (ack_s) begin
                    inj_next_s = INJ_RET;
                end else begin
                    inj_next_s = INJ_REQ;
                end
            end
            INJ_RET: begin
                if (!ack_s) begin
                    inj_next_s = INJ_IDLE;
                end else begin
                    inj_next_s = INJ_RET;
                end
            end
            default: inj_next_s = INJ_IDLE;
        endcase
    end

    // Injection state, registered request and bundled data (held until the next pop)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_state_r <= INJ_IDLE;
            inj_req_r   <= 1'b0;
            inj_data_r  <= 33'd0;
        end else begin
            inj_state_r <= inj_next_s;
            inj_req_r   <= (inj_next_s == INJ_REQ);
            if (pop_s) begin
                inj_data_r <= fifo_mem_r[rd_ptr_r];
            end
        end
    end

    assign inj_req  = inj_req_r;
    assign inj_data = inj_data_r;

`ifdef NI_ADDR_CHECK_EN
    assign accept_s = ej_data[32] && (ej_data[31:28] == SELF_ADDR);
`else
    logic unused_hdr_s;
    assign accept_s     = 1'b1;
    assign unused_hdr_s = ^ej_data[32:28];
`endif

    // Ejection FSM: a pending request waits while the holding register is occupied
    always_comb begin
        ej_next_s = ej_state_r;
        capture_s = 1'b0;
        case (ej_state_r)
            EJ_WAIT: begin
                if (req_s && !rx_valid_r) begin
                    capture_s = 1'b1;
                    ej_next_s = EJ_ACK;
                end else begin
                    ej_next_s = EJ_WAIT;
                end
            end
            EJ_ACK: begin
                if (!req_s) begin
                    ej_next_s = EJ_WAIT;
                end else begin
                    ej_next_s = EJ_ACK;
                end
            end
            default: ej_next_s = EJ_WAIT;
        endcase
    end

    // Ejection state, acknowledge and PE-side holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ej_state_r <= EJ_WAIT;
            ej_ack_r   <= 1'b0;
            rx_valid_r <= 1'b0;
            rx_src_r   <= 4'd0;
            rx_data_r  <= 24'd0;
        end else begin
            ej_state_r <= ej_next_s;
            ej_ack_r   <= (ej_next_s == EJ_ACK);
            if (capture_s && accept_s) begin
                rx_valid_r <= 1'b1;
                rx_src_r   <= ej_data[27:24];
                rx_data_r  <= ej_data[23:0];
            end else if (rx_valid_r && pe_rx_ready) begin
                rx_valid_r <= 1'b0;
            end
        end
    end

    assign ej_ack      = ej_ack_r;
    assign pe_rx_valid = rx_valid_r;
    assign pe_rx_src   = rx_src_r;
    assign pe_rx_data  = rx_data_r;

`ifdef NI_ADDR_CHECK_EN
    logic [7:0] drop_cnt_r;

    // Saturating count of packets acknowledged but rejected by the filter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= 8'd0;
        end else if (capture_s && !accept_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_r;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pe_noc_interface.sv
// Directed, scoreboard-based bench for pe_noc_interface (ADDR 1,1, DEPTH 4).
// Filter/saturation expectations follow whether NI_ADDR_CHECK_EN is defined.
module tb_pe_noc_interface;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pe_tx_valid = 1'b0;
    logic        pe_tx_ready;
    logic [3:0]  pe_tx_dest = 4'd0;
    logic [23:0] pe_tx_data = 24'd0;
    logic        inj_req;
    logic [32:0] inj_data;
    logic        inj_ack = 1'b0;
    logic        ej_req = 1'b0;
    logic [32:0] ej_data = 33'd0;
    logic        ej_ack;
    logic        pe_rx_valid;
    logic        pe_rx_ready = 1'b0;
    logic [3:0]  pe_rx_src;
    logic [23:0] pe_rx_data;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad   = 0;

    logic [32:0] inj_q [$];
    logic [27:0] rx_q [$];

`ifdef NI_ADDR_CHECK_EN
    localparam int SAT_N = 259;
`else
    localparam int SAT_N = 5;
`endif

    always #5 clk = ~clk;

    pe_noc_interface #(.ADDR_X(1), .ADDR_Y(1), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pe_tx_valid (pe_tx_valid),
        .pe_tx_ready (pe_tx_ready),
        .pe_tx_dest  (pe_tx_dest),
        .pe_tx_data  (pe_tx_data),
        .inj_req     (inj_req),
        .inj_data    (inj_data),
        .inj_ack     (inj_ack),
        .ej_req      (ej_req),
        .ej_data     (ej_data),
        .ej_ack      (ej_ack),
        .pe_rx_valid (pe_rx_valid),
        .pe_rx_ready (pe_rx_ready),
        .pe_rx_src   (pe_rx_src),
        .pe_rx_data  (pe_rx_data),
        .drop_cnt    (drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_inj_req(input logic lvl, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (inj_req === lvl) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_ej_ack(input logic lvl, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (ej_ack === lvl) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Router side of one injection: check the offered packet, then complete the handshake
    task automatic router_take();
        logic ok;
        logic [32:0] exp_pkt;
        wait_inj_req(1'b1, 40, ok);
        chk("inj_req_rise", ok, 1);
        exp_pkt = (inj_q.size() > 0) ? inj_q.pop_front() : 33'd0;
        chk("inj_data_sb", inj_data, exp_pkt);
        inj_ack = 1'b1;
        wait_inj_req(1'b0, 10, ok);
        chk("inj_req_fall", ok, 1);
        inj_ack = 1'b0;
        repeat (4) tick();
    endtask

    task automatic eject_send(input logic [32:0] pkt);
        logic ok;
        ej_data = pkt;
        ej_req  = 1'b1;
        wait_ej_ack(1'b1, 12, ok);
        chk("ej_ack_rise", ok, 1);
        ej_req = 1'b0;
        wait_ej_ack(1'b0, 12, ok);
        chk("ej_ack_fall", ok, 1);
    endtask

    initial begin
        logic ok;
        logic [27:0] exp_rx;
        logic [32:0] exp_pkt;

        // Reset values
        repeat (3) tick();
        chk("rst_inj_req", inj_req, 0);
        chk("rst_ej_ack", ej_ack, 0);
        chk("rst_rx_valid", pe_rx_valid, 0);
        chk("rst_inj_data", inj_data, 0);
        chk("rst_rx_data", pe_rx_data, 0);
        chk("rst_rx_src", pe_rx_src, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_tx_ready", pe_tx_ready, 1);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single injection with exact latency
        pe_tx_dest  = 4'b0010;
        pe_tx_data  = 24'h000155;
        pe_tx_valid = 1'b1;
        chk("tx_ready_idle", pe_tx_ready, 1);
        inj_q.push_back(33'h125000155);
        tick();
        pe_tx_valid = 1'b0;
        chk("inj_req_n", inj_req, 0);
        tick();
        chk("inj_data_n1", inj_data, 33'h125000155);
        chk("inj_req_n1", inj_req, 0);
        tick();
        chk("inj_req_n2", inj_req, 1);
        exp_pkt = inj_q.pop_front();
        chk("inj_single_sb", inj_data, exp_pkt);
        inj_ack = 1'b1;
        repeat (2) tick();
        chk("inj_req_ack2", inj_req, 1);
        tick();
        chk("inj_req_ack3", inj_req, 0);
        inj_ack = 1'b0;
        repeat (6) tick();
        chk("inj_idle_quiet", inj_req, 0);
        chk("inj_data_held", inj_data, 33'h125000155);

        // FIFO full with acks withheld: one popped, four queued, sixth refused
        for (int i = 0; i < 6; i++) begin
            pe_tx_dest  = 4'(i);
            pe_tx_data  = 24'hA00000 + 24'(i);
            pe_tx_valid = 1'b1;
            if (i < 5) begin
                chk("tx_ready_fill", pe_tx_ready, 1);
                inj_q.push_back({1'b1, 4'(i), 4'b0101, 24'hA00000 + 24'(i)});
            end else begin
                chk("tx_ready_full", pe_tx_ready, 0);
            end
            tick();
        end
        pe_tx_valid = 1'b0;
        chk("tx_ready_still_full", pe_tx_ready, 0);
        for (int i = 0; i < 5; i++) begin
            router_take();
        end
        chk("tx_ready_drained", pe_tx_ready, 1);
        repeat (6) tick();
        chk("no_extra_pkt", inj_req, 0);

        // Ejection backpressure
        pe_rx_ready = 1'b0;
        rx_q.push_back({4'b1011, 24'h123456});
        ej_data = 33'h15B123456;
        ej_req  = 1'b1;
        repeat (2) tick();
        chk("ej_ack_lat2", ej_ack, 0);
        tick();
        chk("ej_ack_lat3", ej_ack, 1);
        chk("rx_valid_with_ack", pe_rx_valid, 1);
        ej_req = 1'b0;
        wait_ej_ack(1'b0, 12, ok);
        chk("ej_ack_fall_bp", ok, 1);
        rx_q.push_back({4'b0110, 24'hABCDEF});
        ej_data = 33'h156ABCDEF;
        ej_req  = 1'b1;
        repeat (8) tick();
        chk("ej_held", ej_ack, 0);
        chk("rx_valid_held", pe_rx_valid, 1);
        exp_rx = rx_q.pop_front();
        chk("rx_first", {pe_rx_src, pe_rx_data}, exp_rx);
        pe_rx_ready = 1'b1;
        tick();
        pe_rx_ready = 1'b0;
        wait_ej_ack(1'b1, 12, ok);
        chk("ej_second_ack", ok, 1);
        chk("rx_valid_second", pe_rx_valid, 1);
        exp_rx = rx_q.pop_front();
        chk("rx_second", {pe_rx_src, pe_rx_data}, exp_rx);
        ej_req = 1'b0;
        wait_ej_ack(1'b0, 12, ok);
        chk("ej_ack_fall_2", ok, 1);
        pe_rx_ready = 1'b1;
        tick();
        pe_rx_ready = 1'b0;
        chk("rx_consumed", pe_rx_valid, 0);

        // Address filter: dest 0010 is not this node
        ej_data = 33'h12C0000AA;
        ej_req  = 1'b1;
        wait_ej_ack(1'b1, 12, ok);
        chk("flt_ack", ok, 1);
`ifdef NI_ADDR_CHECK_EN
        chk("flt_rx_valid", pe_rx_valid, 0);
        chk("flt_drop", drop_cnt, 1);
`else
        chk("flt_rx_valid", pe_rx_valid, 1);
        chk("flt_rx_payload", {pe_rx_src, pe_rx_data}, {4'hC, 24'h0000AA});
        chk("flt_drop", drop_cnt, 0);
`endif
        ej_req = 1'b0;
        wait_ej_ack(1'b0, 12, ok);
        chk("flt_ack_fall", ok, 1);
        pe_rx_ready = 1'b1;
        tick();

        // Saturation: stream of invalid / misaddressed packets
        for (int i = 0; i < SAT_N; i++) begin
            if (i % 2 == 1) begin
                eject_send({1'b0, 4'b0101, 4'h3, 24'(i)});
            end else begin
                eject_send({1'b1, 4'b1111, 4'h3, 24'(i)});
            end
        end
`ifdef NI_ADDR_CHECK_EN
        chk("drop_saturated", drop_cnt, 255);
`else
        chk("drop_tied_zero", drop_cnt, 0);
`endif

        // Reset in the middle of both handshakes
        pe_tx_dest  = 4'b0011;
        pe_tx_data  = 24'h777777;
        pe_tx_valid = 1'b1;
        tick();
        pe_tx_valid = 1'b0;
        wait_inj_req(1'b1, 10, ok);
        chk("mid_inj_req", ok, 1);
        ej_data = 33'h15B000001;
        ej_req  = 1'b1;
        wait_ej_ack(1'b1, 12, ok);
        chk("mid_ej_ack", ok, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_inj_req", inj_req, 0);
        chk("mrst_ej_ack", ej_ack, 0);
        chk("mrst_tx_ready", pe_tx_ready, 1);
        chk("mrst_drop", drop_cnt, 0);
        chk("mrst_rx_valid", pe_rx_valid, 0);
        chk("mrst_inj_data", inj_data, 0);
        ej_req = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("post_rst_inj_quiet", inj_req, 0);
        chk("post_rst_ej_quiet", ej_ack, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
